// File: rtl/neuron_operand_loader_if.sv
// Element stream in, assembled neuron vector out, plus the length-error pulse.
// The loader uses the slave modport; whoever feeds and drains it uses master.
interface neuron_operand_loader_if #(
  parameter int N  = 2,
  parameter int QM = 6,
  parameter int QN = 10,
  parameter int WM = 6,
  parameter int WN = 10
);
  localparam int QW = QM + QN;
  localparam int WW = WM + WN;

  logic                         s_valid;
  logic                         s_ready;
  logic signed [QW-1:0]         s_in;
  logic signed [WW-1:0]         s_weight;
  logic                         s_bias;
  logic                         s_last;

  logic                         m_valid;
  logic                         m_ready;
  logic signed [N-1:0][QW-1:0]  m_in;
  logic signed [N-1:0][WW-1:0]  m_weights;
  logic                         m_bias;

  logic                         err_len;

  modport master (
    output s_valid, s_in, s_weight, s_bias, s_last, m_ready,
    input  s_ready, m_valid, m_in, m_weights, m_bias, err_len
  );

  modport slave (
    input  s_valid, s_in, s_weight, s_bias, s_last, m_ready,
    output s_ready, m_valid, m_in, m_weights, m_bias, err_len
  );
endinterface

// File: rtl/neuron_operand_loader.sv
// Double-buffered operand loader: elements fill a fill bank; a full bank moves to the
// registered output bank one cycle after completion, so streaming runs bubble-free.
module neuron_operand_loader #(
  parameter int N  = 2,
  parameter int QM = 6,
  parameter int QN = 10,
  parameter int WM = 6,
  parameter int WN = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  neuron_operand_loader_if.slave bus
);
  localparam int QW = QM + QN;
  localparam int WW = WM + WN;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [IW-1:0]        idx;
  logic                 fill_full;
  logic                 fill_bias;
  logic [N-1:0][QW-1:0] fill_in;
  logic [N-1:0][WW-1:0] fill_w;

  logic                 out_vld;
  logic                 out_bias;
  logic [N-1:0][QW-1:0] out_in;
  logic [N-1:0][WW-1:0] out_w;
  logic                 err_q;

  logic                 s_rdy;
  logic                 accept;
  logic                 last_slot;
  logic                 xfer;

  // Stall only when both banks hold a vector and the neuron is not taking one.
  always_comb begin
    xfer      = fill_full && (!out_vld || bus.m_ready);
    s_rdy     = !fill_full || !out_vld || bus.m_ready;
    accept    = bus.s_valid && s_rdy;
    last_slot = (idx == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      fill_full <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= accept && (last_slot ? !bus.s_last : bus.s_last);
      if (accept) begin
        if (last_slot || bus.s_last)
          idx <= '0;
        else
          idx <= idx + 1'b1;
      end
      if (accept && last_slot)
        fill_full <= 1'b1;
      else if (xfer)
        fill_full <= 1'b0;
    end
  end

  // Overwriting slot 0 on a transfer edge is safe: the output bank samples the old contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      fill_in[idx] <= bus.s_in;
      fill_w[idx]  <= bus.s_weight;
      if (idx == '0)
        fill_bias <= bus.s_bias;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_in   <= '0;
      out_w    <= '0;
      out_bias <= 1'b0;
    end else if (xfer) begin
      out_vld  <= 1'b1;
      out_in   <= fill_in;
      out_w    <= fill_w;
      out_bias <= fill_bias;
    end else if (bus.m_ready) begin
      out_vld <= 1'b0;
    end
  end

  assign bus.s_ready   = s_rdy;
  assign bus.m_valid   = out_vld;
  assign bus.m_in      = out_in;
  assign bus.m_weights = out_w;
  assign bus.m_bias    = out_bias;
  assign bus.err_len   = err_q;
endmodule

// File: tb/tb_neuron_operand_loader.sv
// Bench for neuron_operand_loader: directed cycle table, hand-built corner sequences,
// and randomized traffic checked by a queue-based vector scoreboard.
module tb_neuron_operand_loader;
  localparam int N  = 2;
  localparam int QM = 6;
  localparam int QN = 10;
  localparam int WM = 6;
  localparam int WN = 10;
  localparam int QW = QM + QN;
  localparam int WW = WM + WN;
  localparam int WAIT_MAX = 500;
  localparam int REC = 20;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  neuron_operand_loader_if #(.N(N), .QM(QM), .QN(QN), .WM(WM), .WN(WN)) bus ();
  neuron_operand_loader #(.N(N), .QM(QM), .QN(QN), .WM(WM), .WN(WN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic            v;
    logic [QW-1:0]   din;
    logic [WW-1:0]   dw;
    logic            b;
    logic            l;
    logic            mr;
    logic            e_srdy;
    logic            e_mv;
    logic            e_err;
    logic [N*QW-1:0] e_min;
    logic [N*WW-1:0] e_mw;
    logic            e_mb;
  } row_t;

  typedef struct {
    logic [N*QW-1:0] vin;
    logic [N*WW-1:0] vw;
    logic            vb;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  // scoreboard state
  vec_t          exp_q[$];
  logic [QW-1:0] cur_in[$];
  logic [WW-1:0] cur_w[$];
  logic          cur_b;
  int            exp_err = 0;
  int            obs_err = 0;
  int            acc_cnt = 0;
  bit            mon_en = 0;
  bit            mr_rand = 0;
  bit            timed_out = 0;

  bit              hold_vld = 0;
  logic [N*QW-1:0] hold_in;
  logic [N*WW-1:0] hold_w;
  logic            hold_b;

  bit rec_en = 0;
  int rec_cyc = 0;
  bit rec_srdy[REC];
  bit rec_mv[REC];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic row_t mk(input logic v, input logic [QW-1:0] din, input logic [WW-1:0] dw,
                              input logic b, input logic l, input logic mr,
                              input logic es, input logic emv, input logic ee,
                              input logic [N*QW-1:0] emi, input logic [N*WW-1:0] emw,
                              input logic emb);
    row_t r;
    r.v = v; r.din = din; r.dw = dw; r.b = b; r.l = l; r.mr = mr;
    r.e_srdy = es; r.e_mv = emv; r.e_err = ee; r.e_min = emi; r.e_mw = emw; r.e_mb = emb;
    return r;
  endfunction

  function automatic row_t idle(input logic mr, input logic emv,
                                input logic [N*QW-1:0] emi, input logic [N*WW-1:0] emw,
                                input logic emb);
    return mk(1'b0, 16'hDEAD, 16'hBEEF, 1'b1, 1'b1, mr, 1'b1, emv, 1'b0, emi, emw, emb);
  endfunction

  // Reference model: gather elements into a list; N elements make a vector, an early
  // last discards the list, a missing last still completes but counts as an error.
  task automatic model_accept(input logic [QW-1:0] din, input logic [WW-1:0] dw,
                              input logic b, input logic l);
    vec_t v;
    cur_in.push_back(din);
    cur_w.push_back(dw);
    if (cur_in.size() == 1) cur_b = b;
    if (cur_in.size() == N) begin
      for (int k = 0; k < N; k++) begin
        v.vin[k*QW +: QW] = cur_in[k];
        v.vw[k*WW +: WW]  = cur_w[k];
      end
      v.vb = cur_b;
      exp_q.push_back(v);
      if (!l) exp_err++;
      cur_in.delete();
      cur_w.delete();
    end else if (l) begin
      exp_err++;
      cur_in.delete();
      cur_w.delete();
    end
  endtask

  always @(negedge clk) begin
    #4;
    if (mon_en && rst_n) begin
      if (rec_en && rec_cyc < REC) begin
        rec_srdy[rec_cyc] = bus.s_ready;
        rec_mv[rec_cyc]   = bus.m_valid;
        rec_cyc++;
      end
      if (hold_vld) begin
        chk("hold_valid", {63'd0, bus.m_valid}, 64'd1);
        chk("hold_in", {bus.m_in}, hold_in);
        chk("hold_w", {bus.m_weights}, hold_w);
        chk("hold_bias", {63'd0, bus.m_bias}, {63'd0, hold_b});
      end
      hold_vld = bus.m_valid && !bus.m_ready;
      hold_in  = bus.m_in;
      hold_w   = bus.m_weights;
      hold_b   = bus.m_bias;
      if (bus.err_len) obs_err++;
      if (bus.s_valid && bus.s_ready) begin
        acc_cnt++;
        model_accept(bus.s_in, bus.s_weight, bus.s_bias, bus.s_last);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL sb_unexpected_vector actual=%0h required=none", {bus.m_in});
        end else begin
          vec_t e;
          e = exp_q.pop_front();
          chk("sb_in", {bus.m_in}, e.vin);
          chk("sb_w", {bus.m_weights}, e.vw);
          chk("sb_bias", {63'd0, bus.m_bias}, {63'd0, e.vb});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mr_rand) bus.m_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic drive_idle();
    bus.s_valid  = 1'b0;
    bus.s_in     = QW'($urandom);
    bus.s_weight = WW'($urandom);
    bus.s_bias   = 1'($urandom);
    bus.s_last   = 1'($urandom);
  endtask

  // Called at a falling edge; returns at the falling edge after the element is taken.
  task automatic send_elem(input logic [QW-1:0] din, input logic [WW-1:0] dw,
                           input logic b, input logic l, input int gap);
    bit done;
    int t;
    if (timed_out) return;
    for (int g = 0; g < gap; g++) begin
      drive_idle();
      @(negedge clk);
    end
    bus.s_valid  = 1'b1;
    bus.s_in     = din;
    bus.s_weight = dw;
    bus.s_bias   = b;
    bus.s_last   = l;
    done = 0;
    t = 0;
    while (!done) begin
      #4;
      done = bus.s_ready;
      @(negedge clk);
      t++;
      if (!done && t > WAIT_MAX) begin
        n_chk++;
        n_err++;
        timed_out = 1;
        $display("FAIL send_timeout actual=%0d cycles required<=%0d", t, WAIT_MAX);
        drive_idle();
        return;
      end
    end
  endtask

  task automatic drain(input string nm);
    bus.m_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  row_t tbl[$];

  initial begin
    rst_n = 1'b0;
    bus.m_ready = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_m_valid", {63'd0, bus.m_valid}, 64'd0);
    chk("rst_m_in", {bus.m_in}, 64'd0);
    chk("rst_m_weights", {bus.m_weights}, 64'd0);
    chk("rst_m_bias", {63'd0, bus.m_bias}, 64'd0);
    chk("rst_err_len", {63'd0, bus.err_len}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_s_ready", {63'd0, bus.s_ready}, 64'd1);
    @(negedge clk);

    // directed cycle table: nominal vector, idle junk ignored, early last, missing last, stall
    tbl.push_back(mk(1, 16'h0400, 16'h0C00, 1, 0, 1, 1, 0, 0, '0, '0, 0));
    tbl.push_back(mk(1, 16'hFC00, 16'h0400, 0, 1, 1, 1, 0, 0, '0, '0, 0));
    tbl.push_back(idle(1, 1, 32'hFC00_0400, 32'h0400_0C00, 1));
    tbl.push_back(idle(1, 0, '0, '0, 0));
    tbl.push_back(mk(1, 16'h1111, 16'h2222, 1, 1, 1, 1, 0, 1, '0, '0, 0));
    tbl.push_back(mk(1, 16'h0A0A, 16'h0B0B, 0, 0, 1, 1, 0, 0, '0, '0, 0));
    tbl.push_back(mk(1, 16'h0C0C, 16'h0D0D, 1, 1, 1, 1, 0, 0, '0, '0, 0));
    tbl.push_back(idle(1, 1, 32'h0C0C_0A0A, 32'h0D0D_0B0B, 0));
    tbl.push_back(mk(1, 16'h0001, 16'h0002, 1, 0, 1, 1, 0, 0, '0, '0, 0));
    tbl.push_back(mk(1, 16'h0003, 16'h0004, 0, 0, 1, 1, 0, 1, '0, '0, 0));
    tbl.push_back(idle(1, 1, 32'h0003_0001, 32'h0004_0002, 1));
    tbl.push_back(idle(0, 1, 32'h0003_0001, 32'h0004_0002, 1));
    tbl.push_back(idle(1, 0, '0, '0, 0));

    foreach (tbl[i]) begin
      bus.s_valid  = tbl[i].v;
      bus.s_in     = tbl[i].din;
      bus.s_weight = tbl[i].dw;
      bus.s_bias   = tbl[i].b;
      bus.s_last   = tbl[i].l;
      bus.m_ready  = tbl[i].mr;
      #1;
      chk($sformatf("tbl%0d_s_ready", i), {63'd0, bus.s_ready}, {63'd0, tbl[i].e_srdy});
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_m_valid", i), {63'd0, bus.m_valid}, {63'd0, tbl[i].e_mv});
      chk($sformatf("tbl%0d_err_len", i), {63'd0, bus.err_len}, {63'd0, tbl[i].e_err});
      if (tbl[i].e_mv) begin
        chk($sformatf("tbl%0d_m_in", i), {bus.m_in}, tbl[i].e_min);
        chk($sformatf("tbl%0d_m_weights", i), {bus.m_weights}, tbl[i].e_mw);
        chk($sformatf("tbl%0d_m_bias", i), {63'd0, bus.m_bias}, {63'd0, tbl[i].e_mb});
      end
      @(negedge clk);
    end
    drive_idle();
    bus.m_ready = 1'b1;
    @(negedge clk);

    // back-to-back streaming with the neuron always ready
    mon_en  = 1;
    rec_cyc = 0;
    rec_en  = 1;
    for (int v = 0; v < 8; v++)
      for (int k = 0; k < N; k++)
        send_elem(QW'($urandom), WW'($urandom), 1'($urandom), k == N - 1, 0);
    drive_idle();
    while (rec_cyc < REC) @(negedge clk);
    rec_en = 0;
    begin
      int lows, bad;
      lows = 0;
      bad  = 0;
      for (int c = 0; c < 16; c++) if (!rec_srdy[c]) lows++;
      for (int c = 0; c < REC; c++)
        if (rec_mv[c] != (c >= 3 && c <= 17 && (c % 2) == 1)) bad++;
      chk("b2b_s_ready_low_cycles", 64'(lows), 64'd0);
      chk("b2b_m_valid_pattern_errs", 64'(bad), 64'd0);
    end
    drain("b2b_drain");

    // neuron stalls: two vectors buffer, then the loader stops accepting
    bus.m_ready = 1'b0;
    acc_cnt = 0;
    fork
      begin
        for (int v = 0; v < 3; v++)
          for (int k = 0; k < N; k++)
            send_elem(QW'(16'h1000 * (v + 1) + 16'h0101 * k), WW'(16'h2000 + 16'h0010 * v + k),
                      v[0], k == N - 1, 0);
        drive_idle();
      end
      begin
        repeat (6) @(negedge clk);
        #3;
        chk("bp_s_ready", {63'd0, bus.s_ready}, 64'd0);
        chk("bp_m_valid", {63'd0, bus.m_valid}, 64'd1);
        chk("bp_accepted", 64'(acc_cnt), 64'd4);
        chk("bp_m_in", {bus.m_in}, 64'h1101_1000);
        @(negedge clk);
        bus.m_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // reset after element 0 of a vector
    send_elem(16'hAAAA, 16'hBBBB, 1'b1, 1'b0, 0);
    drive_idle();
    #2;
    rst_n = 1'b0;
    cur_in.delete();
    cur_w.delete();
    hold_vld = 0;
    #1;
    chk("mid_rst_m_valid", {63'd0, bus.m_valid}, 64'd0);
    chk("mid_rst_m_in", {bus.m_in}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_s_ready", {63'd0, bus.s_ready}, 64'd1);
    #1;
    exp_err = obs_err;
    send_elem(16'h1111, 16'h2222, 1'b0, 1'b0, 0);
    send_elem(16'h3333, 16'h4444, 1'b1, 1'b1, 0);
    drive_idle();
    drain("rst_drain");
    chk("rst_err_count", 64'(obs_err), 64'(exp_err));

    // randomized traffic with source gaps and neuron stalls
    exp_err = 0;
    obs_err = 0;
    mr_rand = 1;
    for (int v = 0; v < 1000; v++) begin
      int kind;
      kind = $urandom_range(0, 19);
      if (kind == 0) begin
        send_elem(QW'($urandom), WW'($urandom), 1'($urandom), 1'b1, $urandom_range(0, 2));
      end else begin
        for (int k = 0; k < N; k++)
          send_elem(QW'($urandom), WW'($urandom), 1'($urandom),
                    (kind == 1) ? 1'b0 : (k == N - 1),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
    end
    drive_idle();
    mr_rand = 0;
    drain("rand_drain");
    chk("rand_err_count", 64'(obs_err), 64'(exp_err));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/neuron_operand_loader.md
NEURON_OPERAND_LOADER -- requirements
Module: neuron_operand_loader

Interface
REQ-001 SHALL have parameter N, default 2, number of input/weight pairs per neuron vector.
REQ-002 SHALL have parameters QM, QN, default 6, 10, integer and fraction bits of each input sample.
REQ-003 SHALL have parameters WM, WN, default 6, 10, integer and fraction bits of each weight.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port s_valid  input  1  upstream element valid.
REQ-007 SHALL have port s_ready  output  1  loader can accept an element this cycle.
REQ-008 SHALL have port s_in  input  QM+QN signed  input sample.
REQ-009 SHALL have port s_weight  input  WM+WN signed  weight paired with s_in.
REQ-010 SHALL have port s_bias  input  1  bias bit, sampled with element index 0.
REQ-011 SHALL have port s_last  input  1  upstream marks final element of a vector.
REQ-012 SHALL have port m_valid  output  1  complete vector presented to the neuron.
REQ-013 SHALL have port m_ready  input  1  neuron consumes vector this cycle.
REQ-014 SHALL have port m_in  output  N x (QM+QN) signed  assembled inputs, element k at index k.
REQ-015 SHALL have port m_weights  output  N x (WM+WN) signed  assembled weights, index k.
REQ-016 SHALL have port m_bias  output  1  bias of presented vector.
REQ-017 SHALL have port err_len  output  1  one-cycle pulse on vector length mismatch.

Function
REQ-018 SHALL hold a fill bank (N pairs + bias) and an output bank (N pairs + bias), both registered.
REQ-019 SHALL accept an element when s_valid && s_ready, writing it to fill-bank index idx and incrementing idx (0..N-1).
REQ-020 SHALL capture s_bias only on acceptance at idx==0.
REQ-021 SHALL, on acceptance at idx==N-1, mark fill bank FULL and reset idx to 0.
REQ-022 SHALL transfer a FULL fill bank to the output bank when output bank is empty or m_valid && m_ready in the same cycle; m_valid asserts the following cycle.
REQ-023 SHALL, in the transfer-enabled case, transfer the completing element's vector directly (element N-1 accepted at edge t -> m_valid high after edge t+1, i.e. one-cycle latency).
REQ-024 SHALL deassert s_ready only when fill bank FULL and output bank occupied without m_ready; s_ready SHALL be combinational from these registered flags and m_ready.
REQ-025 SHALL sustain one element per cycle when m_ready is held high (no bubbles).
REQ-026 SHALL keep m_in, m_weights, m_bias stable while m_valid && !m_ready.
REQ-027 SHALL clear m_valid after m_valid && m_ready unless a new transfer occurs the same cycle.
REQ-028 SHALL, on accepted s_last at idx<N-1, discard the partial vector, reset idx to 0, pulse err_len.
REQ-029 SHALL, on acceptance at idx==N-1 with s_last==0, still complete the vector and pulse err_len.
REQ-030 SHALL treat element data as opaque: no sign extension, rescaling or saturation.
REQ-031 SHALL ignore s_in/s_weight/s_bias/s_last when s_valid is low or s_ready is low.

Reset
REQ-032 SHALL, on rst_n low, immediately clear idx, FULL flag, m_valid, err_len; m_in, m_weights, m_bias SHALL reset to 0.
REQ-033 SHALL, on reset mid-vector, discard the partial vector; first element after release is index 0.
REQ-034 SHALL drive s_ready high in the first cycle after reset release.

Verification
REQ-035 SHALL cover, N=2: pairs (in=0x0400,w=0x0C00,bias=1),(in=0xFC00,w=0x0400,last=1), m_ready=1 -> m_valid one cycle, m_in={0xFC00,0x0400}, m_weights={0x0400,0x0C00}, m_bias=1.
REQ-036 SHALL cover back-to-back vectors with m_ready=1 and s_valid continuous -> s_ready never low, m_valid every 2nd cycle.
REQ-037 SHALL cover m_ready=0 for 6 cycles during streaming -> exactly 2 vectors buffered, s_ready low thereafter, outputs stable, both delivered in order after m_ready=1.
REQ-038 SHALL cover s_last on element 0 -> err_len single pulse, no m_valid, next two elements form a correct vector.
REQ-039 SHALL cover rst_n low after element 0 accepted -> m_valid=0, next vector assembles from index 0 with its own bias.
REQ-040 SHALL cover random s_valid/m_ready stalls over 1000 vectors against a scoreboard -> no loss, duplication or reorder.
